// File: rtl/rv32i_encode_fmt.sv
// rv32i_encode_fmt: packs RV32I field bundles into instruction words and queues them, with imem byte addresses, in a 2-entry FIFO
module rv32i_encode_fmt #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enc_valid,
    output logic                  enc_ready,
    input  logic [4:0]            enc_opcode,
    input  logic [2:0]            enc_funct3,
    input  logic [6:0]            enc_funct7,
    input  logic [11:0]           enc_funct12,
    input  logic [4:0]            enc_rd,
    input  logic [4:0]            enc_rs1,
    input  logic [4:0]            enc_rs2,
    input  logic [31:0]           enc_imm,
    input  logic                  enc_restart,
    output logic                  imem_valid,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_instruction,
    output logic                  imem_error,
    output logic                  error_sticky
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [24:0] body;
    logic legal, err, shift;
    logic i_bad, sh_bad, b_bad, j_bad, u_bad;
    logic [31:0] word;
    logic bad;
    logic [ADDR_WIDTH-1:0] addr_q, word_addr;
    logic [31:0] mem_instr [2];
    logic [ADDR_WIDTH-1:0] mem_addr [2];
    logic [1:0] mem_err;
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic push, pop;

    assign i_bad  = !(&enc_imm[31:11] || ~|enc_imm[31:11]);
    assign sh_bad = |enc_imm[31:5];
    assign b_bad  = enc_imm[0] || !(&enc_imm[31:12] || ~|enc_imm[31:12]);
    assign j_bad  = enc_imm[0] || !(&enc_imm[31:20] || ~|enc_imm[31:20]);
    assign u_bad  = |enc_imm[11:0];
    assign shift  = enc_funct3[1:0] == 2'b01;

    // Field packing and immediate range check for each supported opcode
    always_comb begin
        body = '0;
        err = 1'b0;
        legal = 1'b1;
        case (enc_opcode)
            5'b00000: begin body = {enc_imm[11:0], enc_rs1, enc_funct3, enc_rd}; err = i_bad; end
            5'b11001: begin body = {enc_imm[11:0], enc_rs1, 3'b000, enc_rd}; err = i_bad; end
            5'b00100: begin
                body = shift ? {enc_funct7, enc_imm[4:0], enc_rs1, enc_funct3, enc_rd}
                             : {enc_imm[11:0], enc_rs1, enc_funct3, enc_rd};
                err = shift ? sh_bad : i_bad;
            end
            5'b01000: begin body = {enc_imm[11:5], enc_rs2, enc_rs1, enc_funct3, enc_imm[4:0]}; err = i_bad; end
            5'b01100: body = {enc_funct7, enc_rs2, enc_rs1, enc_funct3, enc_rd};
            5'b00101, 5'b01101: begin body = {enc_imm[31:12], enc_rd}; err = u_bad; end
            5'b11000: begin
                body = {enc_imm[12], enc_imm[10:5], enc_rs2, enc_rs1, enc_funct3, enc_imm[4:1], enc_imm[11]};
                err = b_bad;
            end
            5'b11011: begin body = {enc_imm[20], enc_imm[10:1], enc_imm[11], enc_imm[19:12], enc_rd}; err = j_bad; end
            5'b11100: body = {enc_funct12, enc_rs1, enc_funct3, enc_rd};
            default: legal = 1'b0;
        endcase
    end

    assign word = legal ? {body, enc_opcode, 2'b11} : 32'h0000_0013;
    assign bad = !legal || err;

    assign enc_ready = !reset && count != 2'd2;
    assign push = enc_valid && enc_ready;
    assign imem_valid = count != 2'd0;
    assign pop = imem_valid && imem_ready;
    assign word_addr = enc_restart ? BASE : addr_q;

    assign imem_address = imem_valid ? mem_addr[rd_ptr] : '0;
    assign imem_instruction = imem_valid ? mem_instr[rd_ptr] : '0;
    assign imem_error = imem_valid && mem_err[rd_ptr];

    // FIFO storage, pointers, address counter and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_instr[0] <= '0;
            mem_instr[1] <= '0;
            mem_addr[0] <= '0;
            mem_addr[1] <= '0;
            mem_err <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= '0;
            addr_q <= BASE;
            error_sticky <= 1'b0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= word;
                mem_addr[wr_ptr] <= word_addr;
                mem_err[wr_ptr] <= bad;
                wr_ptr <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push)
                addr_q <= word_addr + ADDR_WIDTH'(4);
            else if (enc_restart)
                addr_q <= BASE;
            if (push && bad)
                error_sticky <= 1'b1;
            else if (enc_restart)
                error_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv32i_encode_fmt.sv
// tb_rv32i_encode_fmt: directed-vector self-checking bench for rv32i_encode_fmt
module tb_rv32i_encode_fmt;
    logic clk = 1'b0;
    logic reset;
    logic enc_valid, enc_restart, imem_ready;
    logic [4:0] enc_opcode, enc_rd, enc_rs1, enc_rs2;
    logic [2:0] enc_funct3;
    logic [6:0] enc_funct7;
    logic [11:0] enc_funct12;
    logic [31:0] enc_imm;
    logic enc_ready, imem_valid, imem_error, error_sticky;
    logic [9:0] imem_address;
    logic [31:0] imem_instruction;
    logic w_ready, w_valid, w_error, w_sticky;
    logic [3:0] w_address;
    logic [31:0] w_instruction;
    int checks = 0;
    int failures = 0;

    always #5 clk = !clk;

    rv32i_encode_fmt dut (
        .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_opcode(enc_opcode), .enc_funct3(enc_funct3), .enc_funct7(enc_funct7),
        .enc_funct12(enc_funct12), .enc_rd(enc_rd), .enc_rs1(enc_rs1), .enc_rs2(enc_rs2),
        .enc_imm(enc_imm), .enc_restart(enc_restart), .imem_valid(imem_valid),
        .imem_ready(imem_ready), .imem_address(imem_address),
        .imem_instruction(imem_instruction), .imem_error(imem_error), .error_sticky(error_sticky)
    );

    rv32i_encode_fmt #(.ADDR_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(w_ready),
        .enc_opcode(enc_opcode), .enc_funct3(enc_funct3), .enc_funct7(enc_funct7),
        .enc_funct12(enc_funct12), .enc_rd(enc_rd), .enc_rs1(enc_rs1), .enc_rs2(enc_rs2),
        .enc_imm(enc_imm), .enc_restart(enc_restart), .imem_valid(w_valid),
        .imem_ready(imem_ready), .imem_address(w_address),
        .imem_instruction(w_instruction), .imem_error(w_error), .error_sticky(w_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_f(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [11:0] f12, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        enc_opcode = op; enc_funct3 = f3; enc_funct7 = f7; enc_funct12 = f12;
        enc_rd = rd; enc_rs1 = rs1; enc_rs2 = rs2; enc_imm = imm;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] f12, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        set_f(op, f3, f7, f12, rd, rs1, rs2, imm);
        enc_valid = 1'b1;
        step();
        enc_valid = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                        input logic err);
        check({tag, "_valid"}, {31'd0, imem_valid}, 32'd1);
        check({tag, "_instr"}, imem_instruction, instr);
        check({tag, "_addr"}, {22'd0, imem_address}, addr);
        check({tag, "_err"}, {31'd0, imem_error}, {31'd0, err});
    endtask

    initial begin
        reset = 1'b1; enc_valid = 1'b0; enc_restart = 1'b0; imem_ready = 1'b1;
        set_f(5'd0, 3'd0, 7'd0, 12'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, imem_valid}, 32'd0);
        check("rst_ready", {31'd0, enc_ready}, 32'd0);
        check("rst_instr", imem_instruction, 32'd0);
        check("rst_sticky", {31'd0, error_sticky}, 32'd0);
        reset = 1'b0;
        #1 check("ready_up", {31'd0, enc_ready}, 32'd1);

        send(5'b01100, 3'd0, 7'b0100000, 12'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        head("sub", 32'h403100B3, 32'h0, 1'b0);
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        head("addi_m1", 32'hFFF00293, 32'h4, 1'b0);
        send(5'b11000, 3'd0, 7'd0, 12'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        head("beq", 32'h00208463, 32'h8, 1'b0);
        send(5'b11011, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        head("jal", 32'h001000EF, 32'hC, 1'b0);
        check("sticky_clean", {31'd0, error_sticky}, 32'd0);

        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
        head("addi_big", 32'h80000293, 32'h10, 1'b1);
        check("sticky_set", {31'd0, error_sticky}, 32'd1);
        send(5'b00001, 3'd0, 7'd0, 12'd0, 5'd5, 5'd0, 5'd0, 32'd0);
        head("illegal", 32'h00000013, 32'h14, 1'b1);
        enc_restart = 1'b1;
        step();
        enc_restart = 1'b0;
        check("sticky_clr", {31'd0, error_sticky}, 32'd0);
        check("empty_valid", {31'd0, imem_valid}, 32'd0);
        check("empty_instr", imem_instruction, 32'd0);

        send(5'b01000, 3'b010, 7'd0, 12'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
        head("sw", 32'hFE512E23, 32'h0, 1'b0);
        send(5'b01101, 3'd0, 7'd0, 12'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000);
        head("lui", 32'h12345537, 32'h4, 1'b0);
        send(5'b01101, 3'd0, 7'd0, 12'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5001);
        head("lui_bad", 32'h12345537, 32'h8, 1'b1);
        send(5'b11100, 3'd0, 7'd0, 12'd1, 5'd0, 5'd0, 5'd0, 32'd0);
        head("ebreak", 32'h00100073, 32'hC, 1'b0);
        send(5'b00100, 3'b001, 7'd0, 12'd0, 5'd1, 5'd1, 5'd0, 32'd3);
        head("slli", 32'h00309093, 32'h10, 1'b0);
        send(5'b00100, 3'b001, 7'd0, 12'd0, 5'd1, 5'd1, 5'd0, 32'd32);
        head("slli_bad", 32'h00009093, 32'h14, 1'b1);
        send(5'b11001, 3'b111, 7'd0, 12'd0, 5'd1, 5'd2, 5'd0, 32'd4);
        head("jalr", 32'h004100E7, 32'h18, 1'b0);
        send(5'b11000, 3'd0, 7'd0, 12'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        head("beq_odd", 32'h00208363, 32'h1C, 1'b1);

        enc_restart = 1'b1;
        step();
        enc_restart = 1'b0;
        imem_ready = 1'b0;
        set_f(5'b01100, 3'd0, 7'b0100000, 12'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        enc_valid = 1'b1;
        step();
        enc_rd = 5'd2;
        step();
        check("full_ready", {31'd0, enc_ready}, 32'd0);
        enc_rd = 5'd3;
        step();
        check("full_ready2", {31'd0, enc_ready}, 32'd0);
        head("hold", 32'h403100B3, 32'h0, 1'b0);
        imem_ready = 1'b1;
        #1 check("no_comb_ready", {31'd0, enc_ready}, 32'd0);
        step();
        head("drain2", 32'h40310133, 32'h4, 1'b0);
        check("drain_ready", {31'd0, enc_ready}, 32'd1);
        step();
        enc_valid = 1'b0;
        head("drain3", 32'h403101B3, 32'h8, 1'b0);
        step();
        check("drained", {31'd0, imem_valid}, 32'd0);

        enc_restart = 1'b1;
        step();
        enc_restart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'(i));
            check($sformatf("wrap%0d", i), {28'd0, w_address}, 32'((i * 4) % 16));
        end
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        check("rs_a", {28'd0, w_address}, 32'h4);
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        check("rs_b", {28'd0, w_address}, 32'h8);
        enc_restart = 1'b1;
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        enc_restart = 1'b0;
        check("rs_c", {28'd0, w_address}, 32'h0);
        check("rs_c_main", {22'd0, imem_address}, 32'h0);
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        check("rs_d", {28'd0, w_address}, 32'h4);
        check("rs_d_main", {22'd0, imem_address}, 32'h4);

        imem_ready = 1'b0;
        send(5'b00001, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        send(5'b00100, 3'd0, 7'd0, 12'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        check("pre_rst_valid", {31'd0, imem_valid}, 32'd1);
        check("pre_rst_sticky", {31'd0, error_sticky}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, imem_valid}, 32'd0);
        check("arst_instr", imem_instruction, 32'd0);
        check("arst_addr", {22'd0, imem_address}, 32'd0);
        check("arst_err", {31'd0, imem_error}, 32'd0);
        check("arst_sticky", {31'd0, error_sticky}, 32'd0);
        check("arst_ready", {31'd0, enc_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        send(5'b01100, 3'd0, 7'b0100000, 12'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        head("post_rst", 32'h403100B3, 32'h0, 1'b0);
        step();
        check("post_rst_empty", {31'd0, imem_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
